// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter with a small byte FIFO in front of it.
//               Bytes are accepted on in_valid & in_ready, buffered, and
//               shifted out LSB first; back-to-back frames have no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int c_CNT_NEED     = $clog2(c_CLKS_PER_BIT + 1);
    localparam int c_CNT_W        = (c_CNT_NEED > 16) ? c_CNT_NEED : 16;
    localparam int c_PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_PTR_W:0]   c_DEPTH    = (c_PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // FSM / shifter state
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;

    // FIFO state
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    // Next-state / control
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         w_bit_nxt;
    logic               w_tx_nxt;
    logic               w_pop;
    logic               w_push;
    logic               w_bit_end;
    logic               w_nonempty;

    // Ready depends only on the registered count, so a pop while full does
    // not open a slot until the next cycle.
    assign in_ready   = ~rst & (r_count < c_DEPTH);
    assign w_push     = in_valid & in_ready;
    assign w_nonempty = (r_count != '0);
    assign w_bit_end  = (r_cnt == c_CNT_LAST);

    assign tx         = r_tx;
    assign busy       = (r_state != c_ST_IDLE);
    assign fifo_count = r_count;

    // Next-state, bit timing and line level; tx is registered so the line
    // follows the state by one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_tx_nxt    = 1'b1;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = c_ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_DATA: begin
                w_tx_nxt = r_shift[r_bit_idx];
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = c_ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
                    // Chain straight into the next frame when data is waiting
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = c_ST_START;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // FSM state register, bit counters and registered line output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // FIFO pointers, occupancy and shift-register load on pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_shift  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_shift  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; data is captured only on acceptance
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. A bench-side receiver
//               compares every transmitted frame, sample by sample, against
//               the ideal 8N1 waveform of the next expected byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CLOCK_FREQ = 12_000_000;
    localparam int BAUD_RATE  = 115200;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
    localparam int FRAME      = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bit         rx_en = 1'b1;
    bit         rx_active = 1'b0;
    logic [7:0] exp_q [$];
    int         start_q [$];

    uart_tx #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte for a single cycle; exp_ready is the model's view of
    // whether it must be accepted, and only accepted bytes are expected out.
    task automatic push_byte(input logic [7:0] d, input logic exp_ready, input string tag);
        in_data  = d;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, exp_ready);
        if (exp_ready) exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0 || rx_active) && n < 20000) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, (n >= 20000), 0);
        tick();
        check({tag, "_idle_tx"}, tx, 1'b1);
    endtask

    // Bench receiver: captures a full frame of per-cycle samples and checks
    // it against the ideal waveform of the oldest expected byte.
    initial begin : rx
        logic       smp [0:FRAME-1];
        logic [7:0] db;
        logic [7:0] eb;
        logic [9:0] fr;
        int         st;
        int         bad;
        bit         ab;
        forever begin
            @(posedge clk);
            #2;
            if (rx_en && !rst && tx === 1'b0) begin
                rx_active = 1'b1;
                st        = cyc;
                smp[0]    = tx;
                ab        = 1'b0;
                for (int k = 1; k < FRAME; k++) begin
                    @(posedge clk);
                    #2;
                    if (!rx_en) begin
                        ab = 1'b1;
                        break;
                    end
                    smp[k] = tx;
                end
                if (!ab) begin
                    start_q.push_back(st);
                    for (int i = 0; i < 8; i++) db[i] = smp[(i + 1) * CPB + CPB / 2];
                    check("rx_frame_expected", (exp_q.size() > 0), 1);
                    eb  = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    fr  = {1'b1, eb, 1'b0};
                    bad = 0;
                    for (int k = 0; k < FRAME; k++) if (smp[k] !== fr[k / CPB]) bad++;
                    check("rx_byte", db, eb);
                    check("rx_bit_timing_errs", bad, 0);
                end
                rx_active = 1'b0;
            end
        end
    end

    // Global watchdog
    initial begin
        #800_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         n;
        bit         rdy_full;
        logic [7:0] b1, b2, b3;

        // ---------------- reset state ----------------
        in_valid = 1'b1;
        in_data  = 8'hC3;
        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);
        repeat (20) tick();
        check("post_rst_no_start_busy", busy, 1'b0);
        check("post_rst_no_start_tx", tx, 1'b1);

        // ---------------- single byte + latency ----------------
        push_byte(8'h55, 1'b1, "single");
        check("lat_n_fifo_count", fifo_count, 1);
        check("lat_n_busy", busy, 1'b0);
        tick();
        check("lat_n1_busy", busy, 1'b1);
        check("lat_n1_fifo_count", fifo_count, 0);
        check("lat_n1_tx", tx, 1'b1);
        tick();
        check("lat_n2_tx", tx, 1'b0);
        n = 2;
        while (n < 3000) begin
            tick();
            if (busy !== 1'b1) break;
            n++;
        end
        check("single_busy_cycles", n, FRAME);
        wait_done("single");

        // ---------------- back-to-back ----------------
        start_q.delete();
        push_byte(8'hA5, 1'b1, "b2b");
        push_byte(8'h3C, 1'b1, "b2b");
        push_byte(8'hFF, 1'b1, "b2b");
        wait_done("b2b");
        check("b2b_frames", start_q.size(), 3);
        if (start_q.size() >= 3) begin
            check("b2b_gap_1", start_q[1] - start_q[0], FRAME);
            check("b2b_gap_2", start_q[2] - start_q[1], FRAME);
        end

        // ---------------- full FIFO ----------------
        for (int k = 1; k <= 6; k++) push_byte(8'(k), (k <= 5), "full");
        check("full_fifo_count", fifo_count, FIFO_DEPTH);
        check("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (50) tick();
        in_valid = 1'b0;
        check("full_no_overwrite_count", fifo_count, FIFO_DEPTH);
        rdy_full = 1'b0;
        n = 0;
        while (n < 2000) begin
            tick();
            n++;
            if (fifo_count !== 3'(FIFO_DEPTH)) break;
            rdy_full = rdy_full | in_ready;
        end
        check("full_ready_while_full", rdy_full, 1'b0);
        check("full_after_pop_count", fifo_count, FIFO_DEPTH - 1);
        check("full_after_pop_ready", in_ready, 1'b1);
        wait_done("full");

        // ---------------- simultaneous push/pop ----------------
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        b3 = 8'($urandom);
        push_byte(b1, 1'b1, "simul");
        push_byte(b2, 1'b1, "simul");
        repeat (FRAME - 1) tick();
        check("simul_pre_count", fifo_count, 1);
        check("simul_pre_busy", busy, 1'b1);
        push_byte(b3, 1'b1, "simul");
        check("simul_post_count", fifo_count, 1);
        check("simul_post_busy", busy, 1'b1);
        wait_done("simul");

        // ---------------- reset mid-frame ----------------
        push_byte(8'h00, 1'b1, "rstmid");
        push_byte(8'($urandom), 1'b1, "rstmid");
        push_byte(8'($urandom), 1'b1, "rstmid");
        check("rstmid_queued", fifo_count, 2);
        repeat (4 * CPB + CPB / 2 - 1) tick();
        check("rstmid_busy_bit3", busy, 1'b1);
        check("rstmid_tx_bit3", tx, 1'b0);
        rx_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        tick();
        check("rstmid_tx", tx, 1'b1);
        check("rstmid_fifo_count", fifo_count, 0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        tick();
        check("rstmid_release_ready", in_ready, 1'b1);
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            if (busy !== 1'b0 || tx !== 1'b1) n++;
            tick();
        end
        check("rstmid_no_activity", n, 0);
        rx_en = 1'b1;

        // ---------------- randomized bursts ----------------
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                push_byte(8'($urandom), 1'b1, "rand");
                repeat ($urandom_range(0, 20)) tick();
            end
            wait_done("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
